// File: rtl/handshake_constant_match_if.sv
// handshake_constant_match_if: elastic valid/ready channel carrying WIDTH-bit tokens
interface handshake_constant_match_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] data;
  logic valid;
  logic ready;
  modport master (output data, valid, input ready);
  modport slave (input data, valid, output ready);
endinterface

// File: rtl/handshake_constant_match.sv
// handshake_constant_match: compares tokens to a constant, emits 1-bit results via a 2-entry skid buffer
module handshake_constant_match #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] CONST_VALUE = 5,
  parameter int CNT_WIDTH = 16
) (
  input  logic clk,
  input  logic rst,
  handshake_constant_match_if.slave ins,
  handshake_constant_match_if.master outs,
  input  logic clear,
  output logic [CNT_WIDTH-1:0] match_count,
  output logic [CNT_WIDTH-1:0] mismatch_count
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic head, tail, head_nx, tail_nx;
  logic hit, accept, pop;
  logic [CNT_WIDTH-1:0] match_base, mismatch_base;
  assign hit = ins.data == CONST_VALUE;
  assign ins.ready = rst & (state != TWO);
  assign outs.valid = state != EMPTY;
  assign outs.data = head;
  assign accept = ins.valid & ins.ready;
  assign pop = outs.valid & outs.ready;
  always_comb begin
    state_nx = state;
    head_nx = head;
    tail_nx = tail;
    case (state)
      EMPTY: if (accept) begin
        state_nx = ONE;
        head_nx = hit;
      end
      ONE: begin
        state_nx = (accept & !pop) ? TWO : (pop & !accept) ? EMPTY : ONE;
        tail_nx = (accept & !pop) ? hit : tail;
        head_nx = (accept & pop) ? hit : head;
      end
      TWO: if (pop) begin
        state_nx = ONE;
        head_nx = tail;
      end
      default: state_nx = EMPTY;
    endcase
  end
  // clear zeroes the counters first so a same-cycle accept still lands
  assign match_base = clear ? '0 : match_count;
  assign mismatch_base = clear ? '0 : mismatch_count;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= EMPTY;
      head <= 1'b0;
      tail <= 1'b0;
      match_count <= '0;
      mismatch_count <= '0;
    end else begin
      state <= state_nx;
      head <= head_nx;
      tail <= tail_nx;
      match_count <= match_base + CNT_WIDTH'(accept & hit & ~&match_base);
      mismatch_count <= mismatch_base + CNT_WIDTH'(accept & !hit & ~&mismatch_base);
    end
  end
endmodule

// File: tb/tb_handshake_constant_match.sv
// tb_handshake_constant_match: directed and random stimulus against a queue-based reference model
module tb_handshake_constant_match;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear = 1'b0;
  logic [15:0] match_count, mismatch_count;
  int checks = 0;
  int errors = 0;
  bit q[$];
  int m_exp = 0;
  int x_exp = 0;
  handshake_constant_match_if #(.WIDTH(32)) ins_if ();
  handshake_constant_match_if #(.WIDTH(1)) outs_if ();
  handshake_constant_match dut (
    .clk(clk), .rst(rst), .ins(ins_if), .outs(outs_if), .clear(clear),
    .match_count(match_count), .mismatch_count(mismatch_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input bit v, input logic [31:0] d, input bit r, input bit c);
    bit acc, pop;
    ins_if.valid = v;
    ins_if.data = d;
    outs_if.ready = r;
    clear = c;
    #1;
    chk("ins_ready", 32'(ins_if.ready), 32'(q.size() < 2));
    chk("outs_valid", 32'(outs_if.valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("outs", 32'(outs_if.data), 32'(q[0]));
    chk("match_count", 32'(match_count), m_exp);
    chk("mismatch_count", 32'(mismatch_count), x_exp);
    @(posedge clk);
    acc = v && q.size() < 2;
    pop = r && q.size() > 0;
    if (pop) void'(q.pop_front());
    if (c) begin
      m_exp = 0;
      x_exp = 0;
    end
    if (acc) begin
      q.push_back(d == 32'd5);
      if (d == 32'd5) m_exp = (m_exp < 65535) ? m_exp + 1 : m_exp;
      else x_exp = (x_exp < 65535) ? x_exp + 1 : x_exp;
    end
    @(negedge clk);
  endtask
  initial begin
    ins_if.valid = 1'b0;
    ins_if.data = '0;
    outs_if.ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ins_ready", 32'(ins_if.ready), 0);
    chk("rst_outs_valid", 32'(outs_if.valid), 0);
    chk("rst_outs", 32'(outs_if.data), 0);
    chk("rst_match", 32'(match_count), 0);
    chk("rst_mismatch", 32'(mismatch_count), 0);
    rst = 1'b1;
    step(1, 5, 1, 0);
    step(0, 0, 1, 0);
    chk("first_match", 32'(match_count), 1);
    chk("first_mismatch", 32'(mismatch_count), 0);
    step(1, 5, 1, 0);
    step(1, 7, 1, 0);
    step(1, 5, 1, 0);
    step(1, 32'h8000_0005, 1, 0);
    step(0, 0, 1, 0);
    chk("stream_match", 32'(match_count), 3);
    chk("stream_mismatch", 32'(mismatch_count), 2);
    step(1, 5, 0, 0);
    step(1, 6, 0, 0);
    step(1, 5, 0, 0);
    chk("bp_ready_low", 32'(ins_if.ready), 0);
    step(1, 5, 0, 0);
    step(1, 5, 1, 0);
    step(1, 5, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    for (int i = 0; i < 65534; i++) step(1, 5, 1, 0);
    step(0, 0, 1, 0);
    chk("preload_match", 32'(match_count), 32'hFFFE);
    for (int i = 0; i < 3; i++) step(1, 5, 1, 0);
    step(0, 0, 1, 0);
    chk("sat_match", 32'(match_count), 32'hFFFF);
    chk("sat_mismatch", 32'(mismatch_count), 0);
    step(1, 9, 1, 1);
    step(0, 0, 1, 0);
    chk("clear_mismatch", 32'(mismatch_count), 1);
    chk("clear_match", 32'(match_count), 0);
    step(1, 5, 0, 0);
    step(1, 7, 0, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("async_outs_valid", 32'(outs_if.valid), 0);
    chk("async_ins_ready", 32'(ins_if.ready), 0);
    chk("async_match", 32'(match_count), 0);
    chk("async_mismatch", 32'(mismatch_count), 0);
    q.delete();
    m_exp = 0;
    x_exp = 0;
    @(negedge clk);
    rst = 1'b1;
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] d;
      case ($urandom_range(3))
        0: d = 5;
        1: d = 32'h8000_0005;
        2: d = $urandom_range(7);
        default: d = $urandom;
      endcase
      step($urandom_range(9) < 7, d, $urandom_range(9) < 6, $urandom_range(49) == 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
